uart_rx: RTL and testbench

UART receiver, the downstream counterpart of uart_tx. It deserialises the tx line back into W_OUT-bit packets and presents them on a valid/ready master stream. Each packet is NUM_WORDS UART frames: start bit, BITS_PER_WORD data bits LSB first, then PACKET_SIZE-BITS_PER_WORD-1 stop/padding bits that must all be 1. The first frame received fills word 0 (the least significant word).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_word.sv | 136 +++++++++++++
 rtl/uart_rx.sv | 102 ++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    // Single-frame receiver states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;

    localparam int unsigned DEF_CLOCKS_PER_PULSE = 4;
    localparam int unsigned DEF_BITS_PER_WORD    = 8;
    localparam int unsigned DEF_PACKET_SIZE      = DEF_BITS_PER_WORD + 5;

    // Number of UART words that make up one output packet.
    function automatic int unsigned num_words(input int unsigned w_out, input int unsigned bits);
        return w_out / bits;
    endfunction

endpackage

// File: rtl/uart_rx_word.sv
// Input synchroniser plus single-frame receiver: start, data LSB first, stop/padding bits.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = DEF_PACKET_SIZE
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] word,
    output logic                     word_valid,
    output logic                     frame_err
);

    localparam int unsigned CNT_W     = $clog2(CLOCKS_PER_PULSE);
    localparam int unsigned BIDX_W    = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int unsigned STOP_BITS = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int unsigned STOP_W    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(BITS_PER_WORD - 1);
    localparam logic [STOP_W-1:0] STOP_LOAD = STOP_W'(STOP_BITS - 1);

    logic [1:0]               sync_q, sync_d;
    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [STOP_W-1:0]        stop_cnt_q, stop_cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     word_valid_q, word_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     rx_s;

    assign rx_s       = sync_q[1];
    assign word       = shift_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;

    // Two-flop synchroniser shift; the line idles high so the flops reset to 1.
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Frame FSM: times each bit from the falling start edge and samples mid-bit.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                        cnt_d     = CNT_FULL;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = CNT_FULL;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = S_STOP;
                        stop_cnt_d = STOP_LOAD;
                    end else begin
                        bit_idx_d = bit_idx_q + BIDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_FULL;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (stop_cnt_q == '0) begin
                        // Leaving at mid last stop bit lets the next start edge follow immediately.
                        word_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q - STOP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register for synchroniser, FSM, counters and the assembled word.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values, independent of statement order.
        if (!rstn) begin
            sync_q       <= 2'b11;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: gathers NUM_WORDS frames into one packet and offers it on a valid/ready stream.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned  CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int unsigned  BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int unsigned  PACKET_SIZE      = DEF_PACKET_SIZE,
    parameter int unsigned  W_OUT            = 16,
    localparam int unsigned NUM_WORDS        = num_words(W_OUT, BITS_PER_WORD)
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         rx,
    output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]      m_data,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic                                         frame_err,
    output logic                                         overflow
);

    localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [BITS_PER_WORD-1:0]                word;
    logic                                    word_valid;
    logic                                    complete;
    logic [IDX_W-1:0]                        word_idx_q, word_idx_d;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] buf_q, buf_d, packet_w;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] m_data_q, m_data_d;
    logic                                    m_valid_q, m_valid_d;
    logic                                    overflow_q, overflow_d;

    uart_rx_word #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .PACKET_SIZE     (PACKET_SIZE)
    ) u_word (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .word      (word),
        .word_valid(word_valid),
        .frame_err (frame_err)
    );

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign overflow = overflow_q;
    assign complete = word_valid && (word_idx_q == LAST_IDX);

    // Packet assembly, word index tracking and the output handshake.
    always_comb begin
        packet_w             = buf_q;
        packet_w[word_idx_q] = word;
        buf_d                = word_valid ? packet_w : buf_q;

        word_idx_d = word_idx_q;
        if (frame_err) begin
            word_idx_d = '0;
        end else if (word_valid) begin
            word_idx_d = complete ? '0 : word_idx_q + IDX_W'(1);
        end

        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        overflow_d = 1'b0;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (complete) begin
            // A full register is only replaced when the consumer takes the old packet this same cycle.
            if (!m_valid_q || m_ready) begin
                m_data_d  = packet_w;
                m_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_idx_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            word_idx_q <= word_idx_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Packet buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset: word index 0 restarts after reset or a frame error, so every slot is rewritten before a packet is emitted.
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-accurate serial stimulus against a packet-level reference model.
module tb_uart_rx;

    localparam int CPP       = 4;
    localparam int BPW       = 8;
    localparam int PS        = 13;
    localparam int W         = 16;
    localparam int NW        = W / BPW;
    localparam int STOP_BITS = PS - BPW - 1;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      rx;
    logic [NW-1:0][BPW-1:0]    m_data;
    logic                      m_valid;
    logic                      m_ready;
    logic                      frame_err;
    logic                      overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [BPW-1:0] partial[$];
    logic [W-1:0]   exp_q[$];
    int             exp_ferr = 0;
    int             exp_ovf  = 0;
    bit             held     = 1'b0;

    // Observed pulse counts.
    int ferr_seen = 0;
    int ovf_seen  = 0;

    uart_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .PACKET_SIZE     (PS),
        .W_OUT           (W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clocks, then step just past the edge before driving inputs.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPP);
    endtask

    // Packet-level model: one call per frame, made before the frame goes out on the line.
    task automatic model_frame(input logic [BPW-1:0] w, input bit bad);
        logic [W-1:0] pkt;
        if (bad) begin
            exp_ferr++;
            partial.delete();
        end else begin
            partial.push_back(w);
            if (partial.size() == NW) begin
                for (int i = 0; i < NW; i++) pkt[i*BPW +: BPW] = partial[i];
                partial.delete();
                if (held && !m_ready) begin
                    exp_ovf++;
                end else begin
                    exp_q.push_back(pkt);
                    if (!m_ready) held = 1'b1;
                end
            end
        end
    endtask

    // bad_stop < 0 sends a clean frame; otherwise that stop bit is driven low.
    task automatic send_frame(input logic [BPW-1:0] w, input int bad_stop);
        model_frame(w, bad_stop >= 0);
        drive_bit(1'b0);
        for (int i = 0; i < BPW; i++) drive_bit(w[i]);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(i == bad_stop ? 1'b0 : 1'b1);
    endtask

    task automatic send_packet(input logic [W-1:0] p);
        for (int i = 0; i < NW; i++) send_frame(p[i*BPW +: BPW], -1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
        check({tag, "_ovf"}, ovf_seen, exp_ovf);
    endtask

    // Output monitor: scoreboard on handshakes, single-cycle valid, stable data under backpressure.
    logic [W-1:0] prev_data;
    bit           prev_hold   = 1'b0;
    bit           prev_accept = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold   = 1'b0;
            prev_accept = 1'b0;
        end else begin
            if (prev_accept) check("valid_one_cycle", m_valid, 1'b0);
            if (prev_hold && m_valid) check("data_stable", m_data, prev_data);
            if (frame_err) ferr_seen++;
            if (overflow) ovf_seen++;
            if (m_valid && m_ready) begin
                check("pkt_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("pkt_data", m_data, exp_q.pop_front());
            end
            prev_accept = m_valid && m_ready;
            prev_hold   = m_valid && !m_ready;
            prev_data   = m_data;
        end
    end

    initial begin
        logic [W-1:0] pkt;
        logic [W-1:0] cafe;
        int           gap;

        // 1. Reset and quiet line.
        rstn    = 1'b0;
        rx      = 1'b1;
        m_ready = 1'b1;
        tick(2);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rstn = 1'b1;
        tick(50);
        check("idle_m_valid", m_valid, 1'b0);
        check("idle_m_data", m_data, 16'h0000);
        check_pulses("idle");

        // 2. Basic packet plus random packets with random idle gaps.
        send_packet(16'hA55A);
        drain("basic_drain");
        for (int k = 0; k < 10; k++) begin
            pkt = W'($urandom);
            gap = $urandom_range(0, 20);
            if (gap > 0) tick(gap);
            send_packet(pkt);
        end
        drain("random_drain");
        check_pulses("random");

        // 3. One-clock glitch is ignored.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(30);
        check("glitch_m_valid", m_valid, 1'b0);
        check_pulses("glitch");
        send_packet(16'h1234);
        drain("glitch_drain");

        // 4. Framing error on the first word, then a clean packet.
        send_frame(8'h34, 1);
        tick(10);
        check("ferr_no_valid", m_valid, 1'b0);
        check_pulses("ferr");
        send_packet(16'hBEEF);
        drain("ferr_drain");
        check_pulses("ferr_after");

        // 5. Backpressure: second packet dropped with overflow.
        m_ready = 1'b0;
        held    = 1'b0;
        send_packet(16'h1111);
        send_packet(16'h2222);
        tick(10);
        check("bp_valid", m_valid, 1'b1);
        check("bp_data", m_data, 16'h1111);
        check_pulses("bp");
        m_ready = 1'b1;
        held    = 1'b0;
        drain("bp_drain");
        tick(3);
        check("bp_valid_after", m_valid, 1'b0);
        check("bp_data_hold", m_data, 16'h1111);

        // 6. Reset in the middle of word 1, then a clean packet.
        cafe = 16'hCAFE;
        send_frame(cafe[BPW-1:0], -1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(cafe[BPW + i]);
        rx = cafe[BPW + 3];
        tick(2);
        rstn = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, 16'h0000);
        check("mid_rst_frame_err", frame_err, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        partial.delete();
        tick(2);
        rx   = 1'b1;
        rstn = 1'b1;
        tick(5);
        send_packet(cafe);
        drain("cafe_drain");
        check("cafe_data", m_data, 16'hCAFE);
        check_pulses("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
